// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch buffer.
// Entry layout is {pc, inst, cookie, exc}, MSB to LSB.
package fetch_pkg;

    localparam int PC_WIDTH   = 32;
    localparam int INST_WIDTH = 32;
    localparam int DATA_WIDTH = 64;
    localparam int EXC_WIDTH  = 7;
    localparam int NUM_SLOTS  = 2;

    localparam logic [EXC_WIDTH-1:0] EXC_NONE = '0;

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch buffer handshake bundle: cache response side in, decode side out.
// master = cache/decode environment, slave = the fetch buffer itself.
interface fetch_buffer_if
    import fetch_pkg::*;
#(
    parameter int COOKIE_WIDTH = 32
);
    logic                    in_valid;
    logic [PC_WIDTH-1:0]     in_pc;
    logic [DATA_WIDTH-1:0]   in_data;
    logic [COOKIE_WIDTH-1:0] in_cookie;
    logic [EXC_WIDTH-1:0]    in_exception;
    logic                    fetch_ready;

    logic [NUM_SLOTS-1:0]    out_valid;
    logic [PC_WIDTH-1:0]     out_pc0;
    logic [PC_WIDTH-1:0]     out_pc1;
    logic [INST_WIDTH-1:0]   out_inst0;
    logic [INST_WIDTH-1:0]   out_inst1;
    logic [COOKIE_WIDTH-1:0] out_cookie0;
    logic [COOKIE_WIDTH-1:0] out_cookie1;
    logic [EXC_WIDTH-1:0]    out_exc0;
    logic [EXC_WIDTH-1:0]    out_exc1;
    logic [NUM_SLOTS-1:0]    out_ready;

    modport master (
        output in_valid, in_pc, in_data, in_cookie, in_exception,
        input  fetch_ready,
        input  out_valid, out_pc0, out_pc1, out_inst0, out_inst1,
        input  out_cookie0, out_cookie1, out_exc0, out_exc1,
        output out_ready
    );

    modport slave (
        input  in_valid, in_pc, in_data, in_cookie, in_exception,
        output fetch_ready,
        output out_valid, out_pc0, out_pc1, out_inst0, out_inst1,
        output out_cookie0, out_cookie1, out_exc0, out_exc1,
        input  out_ready
    );

endinterface

// File: rtl/fetch_queue_mem.sv
// Entry storage: two write ports (tail, tail+1) and two async reads.
// Ports: clk, we*/waddr*/wdata* writes, raddr*/rdata* reads.
module fetch_queue_mem #(
    parameter int  DEPTH   = 8,
    parameter type entry_t = logic,
    localparam int PW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we0_i,
    input  logic [PW-1:0] waddr0_i,
    input  entry_t        wdata0_i,
    input  logic          we1_i,
    input  logic [PW-1:0] waddr1_i,
    input  entry_t        wdata1_i,
    input  logic [PW-1:0] raddr0_i,
    input  logic [PW-1:0] raddr1_i,
    output entry_t        rdata0_o,
    output entry_t        rdata1_o
);

    entry_t mem_q [DEPTH];

    // Contents are don't-care after reset; validity lives in count.
    always_ff @(posedge clk) begin
        if (we0_i) mem_q[waddr0_i] <= wdata0_i;
        if (we1_i) mem_q[waddr1_i] <= wdata1_i;
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch queue: splits 64-bit cache packets into 32-bit entries.
// Ports: clk, rst, flush, fb (slave bundle), overflow_err (sticky).
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int COOKIE_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    fetch_buffer_if.slave  fb,
    output logic           overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [PC_WIDTH-1:0]     pc;
        logic [INST_WIDTH-1:0]   inst;
        logic [COOKIE_WIDTH-1:0] cookie;
        logic [EXC_WIDTH-1:0]    exc;
    } entry_t;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic [1:0]    n_enq;
    logic [1:0]    n_deq;
    logic [1:0]    enq_amt;
    logic [CW-1:0] space;
    logic          fits;
    logic          do_enq;
    logic [1:0]    vld;
    entry_t        wr0, wr1, rd0, rd1;

    // Faulting fetches carry no usable data, so they take one slot.
    always_comb begin
        n_enq = 2'd1;
        wr0 = '{pc: fb.in_pc, inst: fb.in_data[63:32],
                cookie: fb.in_cookie, exc: EXC_NONE};
        wr1 = '{pc: fb.in_pc + 32'd4, inst: fb.in_data[63:32],
                cookie: fb.in_cookie, exc: EXC_NONE};
        if (fb.in_exception != EXC_NONE) begin
            wr0.inst = '0;
            wr0.exc  = fb.in_exception;
        end else if (!fb.in_pc[2]) begin
            n_enq    = 2'd2;
            wr0.inst = fb.in_data[31:0];
        end
    end

    // Space is judged on the pre-dequeue count.
    assign space   = CW'(DEPTH) - count_q;
    assign fits    = space >= CW'(n_enq);
    assign do_enq  = fb.in_valid && !flush && fits;
    assign enq_amt = do_enq ? n_enq : 2'd0;

    assign vld   = {count_q >= CW'(2), count_q >= CW'(1)};
    assign n_deq = {1'b0, fb.out_ready[0] & vld[0]}
                 + {1'b0, fb.out_ready[1] & vld[1]};

    always_comb begin
        head_d  = head_q + PW'(n_deq);
        tail_d  = tail_q + PW'(enq_amt);
        count_d = count_q + CW'(enq_amt) - CW'(n_deq);
        ovf_d   = ovf_q | (fb.in_valid && !flush && !fits);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            ovf_d   = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    fetch_queue_mem #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_mem (
        .clk      (clk),
        .we0_i    (do_enq),
        .waddr0_i (tail_q),
        .wdata0_i (wr0),
        .we1_i    (do_enq && n_enq == 2'd2),
        .waddr1_i (tail_q + PW'(1)),
        .wdata1_i (wr1),
        .raddr0_i (head_q),
        .raddr1_i (head_q + PW'(1)),
        .rdata0_o (rd0),
        .rdata1_o (rd1)
    );

    // Up to two packets may still land after fetch_ready drops.
    assign fb.fetch_ready = count_q <= CW'(DEPTH - 4);

    assign fb.out_valid   = vld;
    assign fb.out_pc0     = rd0.pc;
    assign fb.out_pc1     = rd1.pc;
    assign fb.out_inst0   = rd0.inst;
    assign fb.out_inst1   = rd1.inst;
    assign fb.out_cookie0 = rd0.cookie;
    assign fb.out_cookie1 = rd1.cookie;
    assign fb.out_exc0    = rd0.exc;
    assign fb.out_exc1    = rd1.exc;

    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized bench for fetch_buffer against a queue-based model.
// Directed scenarios first, then random traffic with flushes and resets.
module tb_fetch_buffer;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic overflow_err;

    always #5 clk = ~clk;

    fetch_buffer_if #(.COOKIE_WIDTH(32)) fbif ();

    fetch_buffer #(
        .DEPTH        (DEPTH),
        .COOKIE_WIDTH (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .fb           (fbif.slave),
        .overflow_err (overflow_err)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] cookie;
        logic [6:0]  exc;
    } ent_t;

    ent_t q[$];
    bit   m_ovf;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) begin
        if (!rst) begin
            assert (fbif.out_ready != 2'b10)
                else $error("illegal out_ready 10");
        end
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic compare_model();
        int n;
        n = q.size();
        check("out_valid", 64'(fbif.out_valid),
              64'({n >= 2, n >= 1}));
        check("fetch_ready", 64'(fbif.fetch_ready),
              64'(n <= DEPTH - 4));
        check("overflow_err", 64'(overflow_err), 64'(m_ovf));
        if (n >= 1) begin
            check("pc0", 64'(fbif.out_pc0), 64'(q[0].pc));
            check("inst0", 64'(fbif.out_inst0), 64'(q[0].inst));
            check("cookie0", 64'(fbif.out_cookie0), 64'(q[0].cookie));
            check("exc0", 64'(fbif.out_exc0), 64'(q[0].exc));
        end
        if (n >= 2) begin
            check("pc1", 64'(fbif.out_pc1), 64'(q[1].pc));
            check("inst1", 64'(fbif.out_inst1), 64'(q[1].inst));
            check("cookie1", 64'(fbif.out_cookie1), 64'(q[1].cookie));
            check("exc1", 64'(fbif.out_exc1), 64'(q[1].exc));
        end
    endtask

    task automatic model_update(input logic v, input logic [31:0] pc,
                                input logic [63:0] d,
                                input logic [31:0] ck,
                                input logic [6:0] ex,
                                input logic [1:0] rdy,
                                input logic fl);
        ent_t e[$];
        int   nd;
        bit   ok;
        if (fl) begin
            q.delete();
            return;
        end
        if (ex != 0) begin
            e.push_back('{pc, 32'h0, ck, ex});
        end else if (pc[2] == 1'b0) begin
            e.push_back('{pc, d[31:0], ck, 7'h0});
            e.push_back('{pc + 32'd4, d[63:32], ck, 7'h0});
        end else begin
            e.push_back('{pc, d[63:32], ck, 7'h0});
        end
        ok = (DEPTH - q.size()) >= e.size();
        nd = 0;
        if (rdy[0] && q.size() >= 1) nd++;
        if (rdy[1] && q.size() >= 2) nd++;
        for (int i = 0; i < nd; i++) void'(q.pop_front());
        if (v) begin
            if (ok) begin
                foreach (e[i]) q.push_back(e[i]);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic step(input logic v, input logic [31:0] pc,
                        input logic [63:0] d, input logic [31:0] ck,
                        input logic [6:0] ex, input logic [1:0] rdy,
                        input logic fl);
        fbif.in_valid     = v;
        fbif.in_pc        = pc;
        fbif.in_data      = d;
        fbif.in_cookie    = ck;
        fbif.in_exception = ex;
        fbif.out_ready    = rdy;
        flush             = fl;
        #1;
        compare_model();
        model_update(v, pc, d, ck, ex, rdy, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [1:0] rdy);
        step(1'b0, 32'h0, 64'h0, 32'h0, 7'h0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fbif.in_valid  = 1'b0;
        fbif.out_ready = 2'b00;
        flush          = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_ovf = 1'b0;
    endtask

    initial begin
        logic        v;
        logic [31:0] pc;
        logic [63:0] d;
        logic [6:0]  ex;
        logic [1:0]  rdy;
        logic        fl;

        fbif.in_valid     = 1'b0;
        fbif.in_pc        = '0;
        fbif.in_data      = '0;
        fbif.in_cookie    = '0;
        fbif.in_exception = '0;
        fbif.out_ready    = '0;

        do_reset();
        check("rst_valid", 64'(fbif.out_valid), 64'h0);
        check("rst_ovf", 64'(overflow_err), 64'h0);
        check("rst_ready", 64'(fbif.fetch_ready), 64'h1);

        // Aligned packet splits into two entries.
        step(1, 32'h1C000000, 64'h00000013_02A00093, 32'hC0C0_0001,
             7'h0, 2'b00, 0);
        check("t1_valid", 64'(fbif.out_valid), 64'h3);
        check("t1_pc0", 64'(fbif.out_pc0), 64'h1C000000);
        check("t1_inst0", 64'(fbif.out_inst0), 64'h02A00093);
        check("t1_pc1", 64'(fbif.out_pc1), 64'h1C000004);
        check("t1_inst1", 64'(fbif.out_inst1), 64'h00000013);

        // Odd-word PC yields one entry from the upper half.
        step(1, 32'h1C000004, 64'hDEADBEEF_11111111, 32'hC0C0_0002,
             7'h0, 2'b11, 0);
        check("t2_valid", 64'(fbif.out_valid), 64'h1);
        check("t2_pc0", 64'(fbif.out_pc0), 64'h1C000004);
        check("t2_inst0", 64'(fbif.out_inst0), 64'hDEADBEEF);

        // Exception: one entry, instruction zeroed.
        step(1, 32'h1C000002, 64'h12345678_9ABCDEF0, 32'hC0C0_0003,
             7'h08, 2'b01, 0);
        check("t3_valid", 64'(fbif.out_valid), 64'h1);
        check("t3_exc0", 64'(fbif.out_exc0), 64'h08);
        check("t3_inst0", 64'(fbif.out_inst0), 64'h0);
        idle(2'b01);

        // Fill to DEPTH with decode stalled.
        for (int k = 0; k < 4; k++) begin
            step(1, 32'h80000000 + 32'(8 * k),
                 {32'hA000_0000 + 32'(2 * k + 1), 32'hA000_0000 + 32'(2 * k)},
                 32'(k), 7'h0, 2'b00, 0);
            check("fill_ready", 64'(fbif.fetch_ready), 64'(k < 2));
        end
        step(1, 32'h80000020, 64'hBBBB_BBBB_AAAA_AAAA, 32'h5,
             7'h0, 2'b00, 0);
        check("ovf_set", 64'(overflow_err), 64'h1);
        check("ovf_full", 64'(fbif.out_valid), 64'h3);
        for (int k = 0; k < 4; k++) idle(2'b11);

        // Hold 3 entries while enqueueing and draining 2 per cycle.
        step(1, 32'h90000000, 64'h2_1, 32'h10, 7'h0, 2'b00, 0);
        step(1, 32'h90000004, 64'h4_3, 32'h11, 7'h0, 2'b00, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 32'h90000008 + 32'(8 * k), {32'(k) + 32'h50, 32'(k) + 32'h40},
                 32'h12 + 32'(k), 7'h0, 2'b11, 0);
            check("steady_valid", 64'(fbif.out_valid), 64'h3);
        end
        for (int k = 0; k < 3; k++) idle(2'b01);

        // Flush with a packet arriving in the same cycle.
        step(1, 32'hA0000000, 64'h6_5, 32'h20, 7'h0, 2'b00, 0);
        step(1, 32'hA0000008, 64'h8_7, 32'h21, 7'h0, 2'b00, 0);
        step(1, 32'hA0000014, 64'h9_0, 32'h22, 7'h0, 2'b00, 0);
        step(1, 32'hA0000018, 64'hB_A, 32'h23, 7'h0, 2'b00, 1);
        check("flush_valid", 64'(fbif.out_valid), 64'h0);
        check("flush_ovf", 64'(overflow_err), 64'h1);
        step(1, 32'hA0000100, 64'hD_C, 32'h24, 7'h0, 2'b00, 0);
        check("post_flush_pc", 64'(fbif.out_pc0), 64'hA0000100);
        idle(2'b11);

        do_reset();
        for (int c = 0; c < 3000; c++) begin
            v  = ($urandom % 3) != 0;
            if (!fbif.fetch_ready && ($urandom % 8) != 0) v = 1'b0;
            pc = $urandom;
            d  = {$urandom, $urandom};
            ex = (($urandom % 8) == 0) ? 7'($urandom_range(1, 127)) : 7'h0;
            case ($urandom % 3)
                0:       rdy = 2'b00;
                1:       rdy = 2'b01;
                default: rdy = 2'b11;
            endcase
            fl = ($urandom % 50) == 0;
            step(v, pc, d, $urandom, ex, rdy, fl);
            if (c == 1500) do_reset();
        end

        do_reset();
        idle(2'b00);
        check("final_ovf", 64'(overflow_err), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
